// File: rtl/data_mem_arbiter_if.sv
// Request/grant bundle between the CPU and host requesters, the arbiter, and the data memory.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              h_req;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic              h_lock;
  logic              h_gnt;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_mode;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Handshake: a requester holds req/we/addr/wdata stable until the cycle where gnt=1;
  // req&&gnt in a cycle is one transfer; a read transfer returns rvalid one cycle later.
  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_rdata,
    input  h_req, h_we, h_addr, h_wdata, h_lock,
    output h_gnt, h_rvalid, h_rdata,
    output mem_addr, mem_mode, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_rdata,
    output h_req, h_we, h_addr, h_wdata, h_lock,
    input  h_gnt, h_rvalid, h_rdata,
    input  mem_addr, mem_mode, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the sort CPU and the host
// loader, with a bounded host lock for bursts.
module data_mem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 32
) (
  input  logic               clk,
  input  logic               rst,
  data_mem_arbiter_if.slave  bus,
  output logic               dbg_state
);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t             state, state_nxt;
  logic               last_host, last_host_nxt;
  logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
  logic               c_pend, c_pend_nxt;
  logic               h_pend, h_pend_nxt;
  logic               c_gnt, h_gnt;

  always_comb begin
    c_gnt         = 1'b0;
    h_gnt         = 1'b0;
    state_nxt     = state;
    last_host_nxt = last_host;
    lock_cnt_nxt  = lock_cnt;
    c_pend_nxt    = 1'b0;
    h_pend_nxt    = 1'b0;

    // Grants are suppressed while rst is high so nothing reaches memory during reset.
    if (!rst) begin
      case (state)
        ST_ARB: begin
          if (bus.c_req && bus.h_req) begin
            c_gnt = last_host;
            h_gnt = !last_host;
          end else begin
            c_gnt = bus.c_req;
            h_gnt = bus.h_req;
          end
          lock_cnt_nxt = '0;
          if (h_gnt && bus.h_lock) state_nxt = ST_LOCK;
        end
        ST_LOCK: begin
          h_gnt        = bus.h_req;
          lock_cnt_nxt = lock_cnt + 1'b1;
          if (!bus.h_lock) begin
            state_nxt = ST_ARB;
          end else if (lock_cnt == CNT_W'(LOCK_MAX - 1)) begin
            state_nxt = ST_ARB;
          end
        end
        default: state_nxt = ST_ARB;
      endcase
    end

    if (c_gnt) last_host_nxt = 1'b0;
    if (h_gnt) last_host_nxt = 1'b1;
    // Forced release hands the next tie to the CPU even if the host transferred this cycle.
    if (state == ST_LOCK && bus.h_lock && lock_cnt == CNT_W'(LOCK_MAX - 1)) last_host_nxt = 1'b1;

    c_pend_nxt = c_gnt && !bus.c_we;
    h_pend_nxt = h_gnt && !bus.h_we;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ARB;
      last_host <= 1'b1;
      lock_cnt  <= '0;
      c_pend    <= 1'b0;
      h_pend    <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_host <= last_host_nxt;
      lock_cnt  <= lock_cnt_nxt;
      c_pend    <= c_pend_nxt;
      h_pend    <= h_pend_nxt;
    end
  end

  // Idle cycles issue a harmless read of address 0.
  always_comb begin
    bus.mem_addr  = ADDR_W'(0);
    bus.mem_mode  = 1'b1;
    bus.mem_wdata = DATA_W'(0);
    if (c_gnt) begin
      bus.mem_addr  = bus.c_addr;
      bus.mem_mode  = ~bus.c_we;
      bus.mem_wdata = bus.c_wdata;
    end else if (h_gnt) begin
      bus.mem_addr  = bus.h_addr;
      bus.mem_mode  = ~bus.h_we;
      bus.mem_wdata = bus.h_wdata;
    end
  end

  assign bus.c_gnt    = c_gnt;
  assign bus.h_gnt    = h_gnt;
  assign bus.c_rvalid = c_pend && !rst;
  assign bus.h_rvalid = h_pend && !rst;
  assign bus.c_rdata  = bus.c_rvalid ? bus.mem_rdata : DATA_W'(0);
  assign bus.h_rdata  = bus.h_rvalid ? bus.mem_rdata : DATA_W'(0);
  assign dbg_state    = (state == ST_LOCK);
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomized bench for data_mem_arbiter: directed scenarios then random traffic, all checked
// against a cycle-level reference model and a read-data scoreboard.
module tb_data_mem_arbiter;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int LOCK_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Single-port memory with registered read data.
  logic [DATA_W-1:0] mem [32];
  always @(posedge clk) begin
    if (bus.mem_mode == 1'b0) mem[bus.mem_addr] <= bus.mem_wdata;
    else                      bus.mem_rdata     <= mem[bus.mem_addr];
  end

  // ---------------- stimulus staging ----------------
  logic              s_rst;
  logic              s_c_req, s_c_we, s_h_req, s_h_we, s_h_lock;
  logic [ADDR_W-1:0] s_c_addr, s_h_addr;
  logic [DATA_W-1:0] s_c_wdata, s_h_wdata;

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [32];
  logic [DATA_W-1:0] c_exp_q[$];
  logic [DATA_W-1:0] h_exp_q[$];
  bit                m_locked;
  int                m_lock_cycles;
  bit                m_last_host;
  bit                m_cg, m_hg;
  int                n_checks = 0;
  int                n_errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_cycle();
    logic [ADDR_W-1:0] e_addr;
    logic              e_mode;
    logic [DATA_W-1:0] e_wdata;
    logic              e_crv, e_hrv;
    logic [DATA_W-1:0] e_crd, e_hrd;

    m_cg = 1'b0;
    m_hg = 1'b0;
    if (!s_rst) begin
      if (m_locked) begin
        m_hg = s_h_req;
      end else if (s_c_req && s_h_req) begin
        m_cg = m_last_host;
        m_hg = !m_last_host;
      end else begin
        m_cg = s_c_req;
        m_hg = s_h_req;
      end
    end

    e_addr = '0; e_mode = 1'b1; e_wdata = '0;
    if (m_cg) begin e_addr = s_c_addr; e_mode = !s_c_we; e_wdata = s_c_wdata; end
    if (m_hg) begin e_addr = s_h_addr; e_mode = !s_h_we; e_wdata = s_h_wdata; end

    e_crv = 1'b0; e_crd = '0; e_hrv = 1'b0; e_hrd = '0;
    if (!s_rst) begin
      if (c_exp_q.size() > 0) begin e_crv = 1'b1; e_crd = c_exp_q.pop_front(); end
      if (h_exp_q.size() > 0) begin e_hrv = 1'b1; e_hrd = h_exp_q.pop_front(); end
    end

    check("c_gnt",     DATA_W'(bus.c_gnt),    DATA_W'(m_cg));
    check("h_gnt",     DATA_W'(bus.h_gnt),    DATA_W'(m_hg));
    check("mem_mode",  DATA_W'(bus.mem_mode), DATA_W'(e_mode));
    check("mem_addr",  DATA_W'(bus.mem_addr), DATA_W'(e_addr));
    check("mem_wdata", bus.mem_wdata,         e_wdata);
    check("c_rvalid",  DATA_W'(bus.c_rvalid), DATA_W'(e_crv));
    check("c_rdata",   bus.c_rdata,           e_crd);
    check("h_rvalid",  DATA_W'(bus.h_rvalid), DATA_W'(e_hrv));
    check("h_rdata",   bus.h_rdata,           e_hrd);
    if (!s_rst) check("lock_state", DATA_W'(dbg_state), DATA_W'(m_locked));

    if (s_rst) begin
      c_exp_q.delete();
      h_exp_q.delete();
      m_locked      = 1'b0;
      m_lock_cycles = 0;
      m_last_host   = 1'b1;
    end else begin
      if (m_cg) begin
        if (s_c_we) ref_mem[s_c_addr] = s_c_wdata;
        else        c_exp_q.push_back(ref_mem[s_c_addr]);
        m_last_host = 1'b0;
      end
      if (m_hg) begin
        if (s_h_we) ref_mem[s_h_addr] = s_h_wdata;
        else        h_exp_q.push_back(ref_mem[s_h_addr]);
        m_last_host = 1'b1;
      end
      // The lock lasts at most LOCK_MAX cycles, then the CPU gets the next tie.
      if (m_locked) begin
        m_lock_cycles++;
        if (!s_h_lock) begin
          m_locked = 1'b0;
        end else if (m_lock_cycles == LOCK_MAX) begin
          m_locked    = 1'b0;
          m_last_host = 1'b1;
        end
      end else if (m_hg && s_h_lock) begin
        m_locked      = 1'b1;
        m_lock_cycles = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic step();
    @(negedge clk);
    rst         = s_rst;
    bus.c_req   = s_c_req;   bus.c_we   = s_c_we;   bus.c_addr = s_c_addr; bus.c_wdata = s_c_wdata;
    bus.h_req   = s_h_req;   bus.h_we   = s_h_we;   bus.h_addr = s_h_addr; bus.h_wdata = s_h_wdata;
    bus.h_lock  = s_h_lock;
    #1;
    model_cycle();
  endtask

  task automatic idle_inputs();
    s_c_req = 0; s_c_we = 0; s_c_addr = '0; s_c_wdata = '0;
    s_h_req = 0; s_h_we = 0; s_h_addr = '0; s_h_wdata = '0; s_h_lock = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int lock_gnts;
    int c_pending, h_pending;
    idle_inputs();
    s_rst = 1;
    foreach (ref_mem[i]) ref_mem[i] = '0;

    // Reset held two cycles with both requesters asking.
    s_c_req = 1; s_h_req = 1;
    step(); step();
    s_rst = 0;
    idle_inputs();

    // Host preloads every word; word 11 gets 9.
    for (int i = 0; i < 32; i++) begin
      s_h_req = 1; s_h_we = 1; s_h_addr = ADDR_W'(i);
      s_h_wdata = (i == 11) ? 32'd9 : $urandom;
      step();
    end
    idle_inputs();

    // CPU reads word 11.
    s_c_req = 1; s_c_addr = 5'd11;
    step();
    idle_inputs();
    step();
    check("cpu_read_11", bus.c_rdata, 32'd9);

    // Both ports read continuously; model checks alternation.
    s_c_req = 1; s_c_addr = 5'd0; s_h_req = 1; s_h_addr = 5'd1;
    for (int i = 0; i < 8; i++) step();
    idle_inputs();
    step();

    // Host write then immediate CPU read of the same word.
    s_h_req = 1; s_h_we = 1; s_h_addr = 5'd3; s_h_wdata = 32'hAA;
    step();
    idle_inputs();
    s_c_req = 1; s_c_addr = 5'd3;
    step();
    idle_inputs();
    step();
    check("raw_addr3", bus.c_rdata, 32'hAA);

    // Locked host burst with the CPU waiting: LOCK_MAX locked host grants, then the CPU.
    s_c_req = 1; s_c_addr = 5'd0; s_h_req = 1; s_h_addr = 5'd2; s_h_lock = 1;
    step();
    check("lock_entry_h_gnt", DATA_W'(bus.h_gnt), 32'd1);
    lock_gnts = 0;
    for (int i = 0; i < LOCK_MAX; i++) begin
      step();
      if (bus.h_gnt && dbg_state && !bus.c_gnt) lock_gnts++;
    end
    check("lock_host_grants", DATA_W'(lock_gnts), DATA_W'(LOCK_MAX));
    step();
    check("cpu_after_lock", DATA_W'(bus.c_gnt), 32'd1);
    idle_inputs();
    step();

    // Reset arriving right after a host read discards that read.
    s_h_req = 1; s_h_addr = 5'd7;
    step();
    idle_inputs();
    s_rst = 1;
    step();
    check("rst_kills_rvalid", DATA_W'(bus.h_rvalid), 32'd0);
    s_rst = 0;
    step();
    check("state_after_rst", DATA_W'(dbg_state), 32'd0);

    // Random traffic honouring hold-until-grant.
    c_pending = 0; h_pending = 0;
    for (int i = 0; i < 3000; i++) begin
      s_rst = ($urandom_range(0, 299) == 0);
      if (!c_pending && $urandom_range(0, 2) != 0) begin
        c_pending = 1; s_c_we = $urandom_range(0, 1);
        s_c_addr = ADDR_W'($urandom); s_c_wdata = $urandom;
      end
      if (!h_pending && $urandom_range(0, 2) != 0) begin
        h_pending = 1; s_h_we = $urandom_range(0, 1);
        s_h_addr = ADDR_W'($urandom); s_h_wdata = $urandom;
      end
      if ($urandom_range(0, 7) == 0) s_h_lock = !s_h_lock;
      s_c_req = c_pending[0];
      s_h_req = h_pending[0];
      step();
      if (m_cg) c_pending = 0;
      if (m_hg) h_pending = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
